sync_edge_filter: RTL and testbench
===================================

# sync_edge_filter

Parametrised multi-channel synchroniser that moves `BUS_WIDTH` independent asynchronous level signals into the `CLK` domain through an `NUM_STAGES`-deep flop chain per channel. It adds an optional per-channel glitch filter and single-cycle rise and fall pulse outputs. It is the successor to the plain multi-flop bit synchroniser and is used at clock-domain and pad boundaries where consumers need clean edge events, not only levels.

## Interface
- `NUM_STAGES`, default 2: synchroniser depth per channel; legal range 2..8.
- `BUS_WIDTH`, default 4: number of independent channels; minimum 1.
- `FILT_CYCLES`, default 4: consecutive stable cycles required before the filtered level changes; legal range 1..255; ignored without `SYNC_FILTER_EN`.

- `CLK` input, 1 bit: destination-domain clock. Reset RST, asynchronous, active-low; clock CLK.
- `RST` input, 1 bit: asynchronous active-low reset.
- `ASYNC` input, `BUS_WIDTH` bits: asynchronous level inputs; each bit is treated as unrelated to the others.
- `SYNC` output, `BUS_WIDTH` bits: synchronised level, filtered when the filter is compiled in; registered.
- `RISE` output, `BUS_WIDTH` bits: one-cycle pulse on a 0→1 transition of `SYNC[i]`.
- `FALL` output, `BUS_WIDTH` bits: one-cycle pulse on a 1→0 transition of `SYNC[i]`.
- `CHANGED` output, 1 bit: OR-reduction of `RISE | FALL`.

## Operation
- Per channel i, stage chain `st[i][0..NUM_STAGES-1]`. On each CLK rising edge: `st[i][0] <= ASYNC[i]` and `st[i][k] <= st[i][k-1]`. The tap is `st[i][NUM_STAGES-1]`.
- Filter, per channel, with counter `cnt[i]` of width clog2(FILT_CYCLES+1):
  - If tap == `SYNC[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == FILT_CYCLES-1`: `SYNC[i] <= tap` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - A tap disagreement shorter than `FILT_CYCLES` consecutive cycles is discarded with no output effect.
  - Any return of the tap to `SYNC[i]` restarts the count from 0.
- Without the filter: `SYNC[i] <= tap` every cycle (one extra register after the chain).
- Edge detect: register `prev[i] <= SYNC[i]`.
  - `RISE[i] = SYNC[i] & ~prev[i]`; `FALL[i] = ~SYNC[i] & prev[i]`. Both are decoded from registers only, with no combinational path from `ASYNC`.
  - Each pulse lasts exactly one cycle per `SYNC` transition. `RISE[i]` and `FALL[i]` are never high together.
- Channels are fully independent; simultaneous changes on several channels yield simultaneous pulses.
- Reset: all stages, `SYNC`, `prev`, and `cnt` clear to 0, so `RISE`, `FALL`, and `CHANGED` read 0. Reset applied mid-filter-count discards the count.
- After reset release with `ASYNC[i]` held at 1, `SYNC[i]` rises after the normal latency and `RISE[i]` pulses once; this is a legitimate edge.

## Timing
- Let edge 0 be the first CLK edge that samples a new stable `ASYNC[i]` value into `st[i][0]`.
- Without filter: tap holds the value after edge `NUM_STAGES-1`. `SYNC[i]` updates at edge `NUM_STAGES`, and the `RISE`/`FALL` pulse is high in the cycle following edge `NUM_STAGES`.
- With filter: `SYNC[i]` updates at edge `NUM_STAGES-1+FILT_CYCLES`, with the pulse in the following cycle. `FILT_CYCLES=1` gives the same latency as no filter.
- Minimum input pulse guaranteed to pass the filter: `FILT_CYCLES` CLK periods plus one period of sampling uncertainty.
- Reset assertion is asynchronous. Deassertion must be synchronised externally to `CLK`.

## Configuration
- Macro `SYNC_FILTER_EN`.
  - Defined: the per-channel counters and the filter logic above are built, and `FILT_CYCLES` is honoured.
  - Undefined: no counters are instantiated, `SYNC` follows the tap with one register delay, and `FILT_CYCLES` has no effect.
- Port list is identical in both builds.

## Test plan
- Reset: hold RST=0 with `ASYNC`=4'hF. Required: `SYNC`=0, `RISE`=`FALL`=0, `CHANGED`=0. Release RST, then `SYNC`=4'hF after 2 edges (no filter) or 5 edges (filter, `FILT_CYCLES`=4). `RISE`=4'hF for exactly 1 cycle.
- Latency, `NUM_STAGES`=3, no filter: toggle `ASYNC[2]` 0→1. Required: `SYNC[2]`=1 at the 3rd edge, `RISE[2]` high for 1 cycle, `FALL`=0.
- Glitch reject, filter on, `FILT_CYCLES`=4: 3-cycle high pulse on `ASYNC[0]`. Required: `SYNC[0]` stays 0 and no `RISE`. A 6-cycle pulse gives a `RISE[0]` pulse and a later `FALL[0]` pulse, each 1 cycle wide.
- Count restart: drive the tap sequence 1,1,1,0,1,1,1,1 against `SYNC`=0. Required: `SYNC` changes only after the final 4 consecutive ones.
- Simultaneous channels: `ASYNC` 4'b0101→4'b1010 on one edge. Required: `RISE`=4'b1010 and `FALL`=4'b0101 in the same cycle, with `CHANGED`=1 for 1 cycle.
- Reset mid-count: assert RST while `cnt[1]`=2. Required: immediate clear of all outputs and counters, with no pulse after release if `ASYNC`=0.

Source files
------------

// File: rtl/sync_edge_filter.sv
// Multi-channel level synchroniser with optional glitch filter and rise/fall pulse outputs.
// Build option: define SYNC_FILTER_EN to add the per-channel FILT_CYCLES stability filter.
module sync_edge_filter #(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned BUS_WIDTH   = 4,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 CHANGED
);

  logic [BUS_WIDTH-1:0][NUM_STAGES-1:0] st_q, st_d;
  logic [BUS_WIDTH-1:0]                 tap;
  logic [BUS_WIDTH-1:0]                 sync_q, sync_d;
  logic [BUS_WIDTH-1:0]                 prev_q;

  // Per-channel flop chain; bit 0 is the metastability-exposed capture flop.
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      st_d[i] = {st_q[i][NUM_STAGES-2:0], ASYNC[i]};
      tap[i]  = st_q[i][NUM_STAGES-1];
    end
  end

`ifdef SYNC_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

  logic [BUS_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Level only moves after FILT_CYCLES consecutive disagreeing tap samples.
  always_comb begin
    sync_d = sync_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      if (tap[i] == sync_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(FILT_CYCLES - 1)) begin
        sync_d[i] = tap[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  always_comb begin
    sync_d = tap;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q   <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      st_q   <= st_d;
      sync_q <= sync_d;
      prev_q <= sync_q;
    end
  end

  // Edge pulses decode only from registers, so no path from ASYNC reaches them.
  assign SYNC    = sync_q;
  assign RISE    = sync_q & ~prev_q;
  assign FALL    = ~sync_q & prev_q;
  assign CHANGED = |(RISE | FALL);

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter (NUM_STAGES=3, FILT_CYCLES=4); follows SYNC_FILTER_EN.
module tb_sync_edge_filter;

  localparam int unsigned NS = 3;
  localparam int unsigned BW = 4;
  localparam int unsigned FC = 4;
`ifdef SYNC_FILTER_EN
  localparam int LAT = NS + FC - 1;
`else
  localparam int LAT = NS;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] ASYNC;
  logic [BW-1:0] SYNC;
  logic [BW-1:0] RISE;
  logic [BW-1:0] FALL;
  logic          CHANGED;

  sync_edge_filter #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .FILT_CYCLES(FC)) dut (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC), .SYNC(SYNC),
    .RISE(RISE), .FALL(FALL), .CHANGED(CHANGED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] async_v;
    logic [3:0] sync_v;
    logic [3:0] rise_v;
    logic [3:0] fall_v;
  } vec_t;

  vec_t tbl [7];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply a new level, then check the exact edge where SYNC and the pulse appear.
  task automatic run_level(input string name, input logic [3:0] a, input logic [3:0] prev_s,
                           input logic [3:0] es, input logic [3:0] er, input logic [3:0] ef);
    ASYNC = a;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      if (e == LAT - 1) begin
        chk({name, " sync_before"}, SYNC, prev_s);
        chk({name, " quiet_before"}, RISE | FALL, 4'h0);
      end
      if (e == LAT) begin
        chk({name, " sync"}, SYNC, es);
        chk({name, " rise"}, RISE, er);
        chk({name, " fall"}, FALL, ef);
        chk({name, " changed"}, {3'b0, CHANGED}, {3'b0, |(er | ef)});
      end
      if (e == LAT + 1) begin
        chk({name, " sync_hold"}, SYNC, es);
        chk({name, " pulse_end"}, RISE | FALL, 4'h0);
        chk({name, " changed_end"}, {3'b0, CHANGED}, 4'h0);
      end
    end
  endtask

  initial begin
    logic [3:0] prev_s;
    logic [7:0] rs;
    logic       exp_b;

    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    tbl[1] = '{4'b0101, 4'b0101, 4'b0101, 4'b0000};
    tbl[2] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101};
    tbl[3] = '{4'b1000, 4'b1000, 4'b0000, 4'b0010};
    tbl[4] = '{4'b1100, 4'b1100, 4'b0100, 4'b0000};
    tbl[5] = '{4'b0011, 4'b0011, 4'b0011, 4'b1100};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011};

    // Reset held with inputs high: everything stays clear.
    RST   = 1'b0;
    ASYNC = 4'hF;
    repeat (4) tick();
    chk("rst sync", SYNC, 4'h0);
    chk("rst rise", RISE, 4'h0);
    chk("rst fall", FALL, 4'h0);
    chk("rst changed", {3'b0, CHANGED}, 4'h0);

    // Release: high inputs produce one legitimate rise.
    @(negedge CLK);
    RST = 1'b1;
    run_level("release", 4'hF, 4'h0, 4'hF, 4'hF, 4'h0);

    prev_s = 4'hF;
    for (int v = 0; v < 7; v++) begin
      run_level($sformatf("vec%0d", v), tbl[v].async_v, prev_s,
                tbl[v].sync_v, tbl[v].rise_v, tbl[v].fall_v);
      prev_s = tbl[v].sync_v;
    end

    // Three-cycle pulse on channel 0.
    for (int c = 0; c < 18; c++) begin
      ASYNC = {3'b000, (c < 3)};
      tick();
`ifdef SYNC_FILTER_EN
      exp_b = 1'b0;
`else
      exp_b = (c >= LAT) && (c < LAT + 3);
`endif
      chk($sformatf("short c%0d sync", c), {3'b0, SYNC[0]}, {3'b0, exp_b});
      chk($sformatf("short c%0d rise", c), {3'b0, RISE[0]}, {3'b0, exp_b && (c == LAT)});
    end

    // Six-cycle pulse passes in both builds: rise at LAT, fall six edges later.
    for (int c = 0; c < 22; c++) begin
      ASYNC = {3'b000, (c < 6)};
      tick();
      chk($sformatf("long c%0d rise", c), {3'b0, RISE[0]}, {3'b0, c == LAT});
      chk($sformatf("long c%0d fall", c), {3'b0, FALL[0]}, {3'b0, c == LAT + 6});
    end

    // Restart sequence 1,1,1,0,1,1,1,1 on channel 0.
    rs = 8'hF7;
    for (int c = 0; c < 20; c++) begin
      ASYNC = {3'b000, (c < 8) ? rs[c] : 1'b0};
      tick();
`ifdef SYNC_FILTER_EN
      exp_b = (c >= 10) && (c <= 13);
`else
      exp_b = (c >= 3) && (c <= 10) ? rs[c-3] : 1'b0;
`endif
      chk($sformatf("restart c%0d sync", c), {3'b0, SYNC[0]}, {3'b0, exp_b});
    end

    // Reset in the middle of channel 1 counting (cnt[1]=2 after edge 4).
    ASYNC = 4'b0010;
    repeat (5) tick();
    RST = 1'b0;
    #1;
    chk("midrst sync", SYNC, 4'h0);
    chk("midrst rise", RISE, 4'h0);
    chk("midrst fall", FALL, 4'h0);
    chk("midrst changed", {3'b0, CHANGED}, 4'h0);
    ASYNC = 4'h0;
    repeat (2) tick();
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("post c%0d sync", c), SYNC, 4'h0);
      chk($sformatf("post c%0d edges", c), RISE | FALL, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
